// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if.sv
// Bundle for the pipelined NOR/OR reduction tree.
// The master side produces operands and consumes results.
// The slave side is the reduction pipe.
// CNT and CNT_CLR exist only when GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN is defined.
interface gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(
  parameter int WIDTH = 32
`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [WIDTH-1:0] A;        // operand vector
  logic             IVLD;     // A valid this cycle
  logic             IRDY;     // pipe accepts A this cycle
  logic             ZN;       // reduction result, 0 while OVLD=0
  logic             OVLD;     // ZN valid
  logic             ORDY;     // downstream takes ZN this cycle
`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
  logic [CNT_W-1:0] CNT;      // count of delivered ZN==1 results
  logic             CNT_CLR;  // synchronous clear of CNT
`endif

  modport master (
    output A, IVLD, ORDY,
    input  IRDY, ZN, OVLD
`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
    , output CNT_CLR
    , input  CNT
`endif
  );

  modport slave (
    input  A, IVLD, ORDY,
    output IRDY, ZN, OVLD
`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
    , input  CNT_CLR
    , output CNT
`endif
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe.sv
// Pipelined WIDTH-input NOR (MODE=0) or OR (MODE=1) reduction with valid/ready flow control.
// A is zero-padded to a power of two, P = 2**clog2(WIDTH).
// The L = clog2(P) OR levels are spread over STAGES register stages, with K = ceil(L/STAGES) levels per stage.
// Latency is STAGES cycles and throughput is one result per cycle.
// IRDY is combinational from ORDY; there is no skid buffer.
// Optional hit counter: define GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN to build CNT/CNT_CLR.
// Without that macro, CNT_W only feeds a parameter sanity check.
// The interface WIDTH/CNT_W must match the parameters given here.
module gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if.slave bus
);

  // Tree geometry: L levels over a P-wide padded operand.
  localparam int L     = $clog2(WIDTH);
  localparam int P     = 1 << L;
  localparam int STG_D = (STAGES < 1) ? 1 : STAGES;
  localparam int K     = (L + STG_D - 1) / STG_D;

  // Parameter sanity checks.
  // An illegal configuration stops at elaboration rather than building a broken tree.
  if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
    $error("nor_tree_pipe: WIDTH must be in 2..256");
  end
  if (STAGES < 1 || STAGES > L) begin : g_bad_stages
    $error("nor_tree_pipe: STAGES must be in 1..clog2(WIDTH)");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("nor_tree_pipe: CNT_W must be at least 1");
  end

  // Zero padding is neutral for OR, so the unused top bits never affect the result.
  logic [P-1:0] a_pad;

  // Zero-extend the operand into the power-of-two tree input.
  always_comb begin
    a_pad            = '0;
    a_pad[WIDTH-1:0] = bus.A;
  end

  // Per-stage logic.
  // Stage gi collapses tree levels [LO, HI).
  // Each registered bit is therefore the OR of a 2**(HI-LO)-bit group of its input.
  // Stages past the last level (HI == LO) simply re-register a single bit.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO    = (gi * K < L) ? gi * K : L;
    localparam int HI    = ((gi + 1) * K < L) ? (gi + 1) * K : L;
    localparam int IN_W  = P >> LO;
    localparam int OUT_W = P >> HI;
    localparam int GRP   = 1 << (HI - LO);

    logic [IN_W-1:0]  stage_in;
    logic [OUT_W-1:0] or_next;
    logic [OUT_W-1:0] data_reg;
    logic             vld_reg;
    logic             vld_in;
    logic             rdy;
    logic             rdy_down;

    // Source of this stage: the padded operand, or the previous stage's partial ORs.
    if (gi == 0) begin : g_src
      assign stage_in = a_pad;
      assign vld_in   = bus.IVLD;
    end else begin : g_src
      assign stage_in = g_stage[gi-1].data_reg;
      assign vld_in   = g_stage[gi-1].vld_reg;
    end

    // Ready from downstream: the next stage, or the output port for the last stage.
    if (gi == STAGES - 1) begin : g_dst
      assign rdy_down = bus.ORDY;
    end else begin : g_dst
      assign rdy_down = g_stage[gi+1].rdy;
    end

    // A stage can take new contents when it is empty or its contents move on this cycle.
    assign rdy = ~vld_reg | rdy_down;

    // Group ORs; each group is the balanced 2-input OR sub-tree of HI-LO levels.
    for (genvar gj = 0; gj < OUT_W; gj++) begin : g_or
      assign or_next[gj] = |stage_in[gj*GRP +: GRP];
    end

    // Stage register: load on rdy, otherwise hold both valid and data unchanged.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        vld_reg  <= 1'b0;
        data_reg <= '0;
      end else if (rdy) begin
        vld_reg  <= vld_in;
        data_reg <= or_next;
      end
    end
  end

  // Output side.
  logic or_final;
  logic out_vld;
  logic zn_val;

  assign or_final = g_stage[STAGES-1].data_reg[0];
  assign out_vld  = g_stage[STAGES-1].vld_reg;
  assign zn_val   = (MODE != 0) ? or_final : ~or_final;

  assign bus.OVLD = out_vld;
  // Force ZN low while no result is presented, so it is never driven from stale data.
  assign bus.ZN   = out_vld & zn_val;
  assign bus.IRDY = g_stage[0].rdy;

`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             hit;

  // A hit is a delivered result (out transfer) whose ZN is 1.
  assign hit = out_vld & bus.ORDY & zn_val;

  // Saturating hit counter; a clear in the same cycle as a hit wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (bus.CNT_CLR) begin
      cnt_reg <= '0;
    end else if (hit && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.CNT = cnt_reg;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe.sv
// Directed bench for the pipelined NOR/OR reduction tree.
// It uses three instances:
//   u_nor32 - WIDTH=32, STAGES=2, MODE=0
//   u_or32  - WIDTH=32, STAGES=2, MODE=1
//   u_nor5  - WIDTH=5,  STAGES=3, MODE=0, CNT_W=2
// Hit-counter checks are built when GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN is defined.
module tb_gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(.WIDTH(32), .CNT_W(16)) if0 ();
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(.WIDTH(32), .CNT_W(16)) if1 ();
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(.WIDTH(5),  .CNT_W(2))  if2 ();
`else
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(.WIDTH(32)) if0 ();
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(.WIDTH(32)) if1 ();
  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe_if #(.WIDTH(5))  if2 ();
`endif

  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe #(.WIDTH(32), .STAGES(2), .MODE(0), .CNT_W(16)) u_nor32 (
    .CLK (clk),
    .RST (rst),
    .bus (if0)
  );

  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe #(.WIDTH(32), .STAGES(2), .MODE(1), .CNT_W(16)) u_or32 (
    .CLK (clk),
    .RST (rst),
    .bus (if1)
  );

  gf180mcu_fd_sc_mcu9t5v0__nor_tree_pipe #(.WIDTH(5), .STAGES(3), .MODE(0), .CNT_W(2)) u_nor5 (
    .CLK (clk),
    .RST (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the same inputs to both 32-bit instances.
  task automatic drv32(input logic v, input logic [31:0] a, input logic ordy);
    if0.IVLD = v;
    if0.A    = a;
    if0.ORDY = ordy;
    if1.IVLD = v;
    if1.A    = a;
    if1.ORDY = ordy;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    if2.IVLD = 1'b0;
    if2.A    = '0;
    if2.ORDY = 1'b1;
`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
    if0.CNT_CLR = 1'b0;
    if1.CNT_CLR = 1'b0;
    if2.CNT_CLR = 1'b0;
`endif
    // Reset with a valid operand present.
    drv32(1'b1, 32'h0, 1'b1);
    if2.IVLD = 1'b1;
    tick();
    tick();
    chk("rst_ovld",  {31'b0, if0.OVLD}, 32'd0);
    chk("rst_zn",    {31'b0, if0.ZN},   32'd0);
    chk("rst_irdy",  {31'b0, if0.IRDY}, 32'd1);
    chk("rst_ovld5", {31'b0, if2.OVLD}, 32'd0);
    rst      = 1'b0;
    if2.IVLD = 1'b0;
    drv32(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    chk("post_rst_ovld", {31'b0, if0.OVLD}, 32'd0);

    // Latency: exactly two cycles for STAGES=2.
    drv32(1'b1, 32'h0, 1'b1);
    tick();
    drv32(1'b0, 32'h0, 1'b1);
    chk("lat_ovld_c1", {31'b0, if0.OVLD}, 32'd0);
    tick();
    chk("lat_ovld_c2", {31'b0, if0.OVLD}, 32'd1);
    chk("lat_nor_zero", {31'b0, if0.ZN}, 32'd1);
    chk("lat_or_zero",  {31'b0, if1.ZN}, 32'd0);
    drv32(1'b1, 32'h0001_0000, 1'b1);
    tick();
    drv32(1'b0, 32'h0, 1'b1);
    tick();
    chk("lat_nor_bit16", {31'b0, if0.ZN}, 32'd0);
    chk("lat_or_bit16",  {31'b0, if1.ZN}, 32'd1);
    tick();
    chk("lat_drained", {31'b0, if0.OVLD}, 32'd0);

    // Streaming: 8 back-to-back operands, no bubbles.
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        drv32(1'b1, (c % 2 == 0) ? 32'h0 : (32'h1 << c), 1'b1);
        chk($sformatf("strm_irdy%0d", c), {31'b0, if0.IRDY}, 32'd1);
      end else begin
        drv32(1'b0, 32'h0, 1'b1);
      end
      tick();
      if (c >= 1) begin
        chk($sformatf("strm_ovld%0d", c - 1), {31'b0, if0.OVLD}, 32'd1);
        chk($sformatf("strm_zn%0d", c - 1), {31'b0, if0.ZN}, ((c - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("strm_or%0d", c - 1), {31'b0, if1.ZN}, ((c - 1) % 2 == 0) ? 32'd0 : 32'd1);
      end
    end
    tick();
    chk("strm_drained", {31'b0, if0.OVLD}, 32'd0);

    // Back-pressure: ORDY=0 for five cycles.
    drv32(1'b1, 32'h0, 1'b0);
    chk("bp_irdy0", {31'b0, if0.IRDY}, 32'd1);
    tick();
    drv32(1'b1, 32'h8000_0000, 1'b0);
    chk("bp_irdy1", {31'b0, if0.IRDY}, 32'd1);
    chk("bp_ovld1", {31'b0, if0.OVLD}, 32'd0);
    tick();
    for (int c = 2; c < 5; c++) begin
      drv32(1'b1, 32'h0, 1'b0);
      chk($sformatf("bp_irdy%0d", c), {31'b0, if0.IRDY}, 32'd0);
      chk($sformatf("bp_hold_ovld%0d", c), {31'b0, if0.OVLD}, 32'd1);
      chk($sformatf("bp_hold_zn%0d", c), {31'b0, if0.ZN}, 32'd1);
      tick();
    end
    // Full pipe with in and out together; the third operand (0) enters.
    drv32(1'b1, 32'h0, 1'b1);
    chk("bp_irdy_comb", {31'b0, if0.IRDY}, 32'd1);
    chk("bp_out0", {31'b0, if0.ZN}, 32'd1);
    tick();
    drv32(1'b0, 32'h0, 1'b1);
    chk("bp_out1_vld", {31'b0, if0.OVLD}, 32'd1);
    chk("bp_out1", {31'b0, if0.ZN}, 32'd0);
    tick();
    chk("bp_out2_vld", {31'b0, if0.OVLD}, 32'd1);
    chk("bp_out2", {31'b0, if0.ZN}, 32'd1);
    tick();
    chk("bp_empty", {31'b0, if0.OVLD}, 32'd0);

    // Asynchronous reset while holding a result.
    drv32(1'b1, 32'h0, 1'b0);
    tick();
    tick();
    drv32(1'b0, 32'h0, 1'b0);
    chk("mid_full", {31'b0, if0.OVLD}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ovld", {31'b0, if0.OVLD}, 32'd0);
    chk("mid_rst_zn",   {31'b0, if0.ZN},   32'd0);
    chk("mid_rst_irdy", {31'b0, if0.IRDY}, 32'd1);
    tick();
    rst = 1'b0;
    drv32(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    chk("mid_rst_noout", {31'b0, if0.OVLD}, 32'd0);

    // Odd width with padding: WIDTH=5, STAGES=3.
    if2.A    = 5'b10000;
    if2.IVLD = 1'b1;
    tick();
    if2.IVLD = 1'b0;
    tick();
    chk("w5_ovld_c2", {31'b0, if2.OVLD}, 32'd0);
    tick();
    chk("w5_ovld_c3", {31'b0, if2.OVLD}, 32'd1);
    chk("w5_zn_msb",  {31'b0, if2.ZN},   32'd0);
    if2.A    = 5'b00000;
    if2.IVLD = 1'b1;
    tick();
    if2.IVLD = 1'b0;
    tick();
    tick();
    chk("w5_zn_zero", {31'b0, if2.ZN}, 32'd1);
    tick();

`ifdef GF180MCU_FD_SC_MCU9T5V0__NOR_TREE_CNT_EN
    // Hit counter: three hits, one miss.
    if0.CNT_CLR = 1'b1;
    if2.CNT_CLR = 1'b1;
    tick();
    if0.CNT_CLR = 1'b0;
    if2.CNT_CLR = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drv32(1'b1, (c == 2) ? 32'h4 : 32'h0, 1'b1);
      tick();
    end
    drv32(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    chk("cnt_three", 32'(if0.CNT), 32'd3);
    // Clear in the same cycle as a hit.
    drv32(1'b1, 32'h0, 1'b1);
    tick();
    drv32(1'b0, 32'h0, 1'b1);
    tick();
    if0.CNT_CLR = 1'b1;
    tick();
    if0.CNT_CLR = 1'b0;
    chk("cnt_clr_wins", 32'(if0.CNT), 32'd0);
    // Saturation with CNT_W=2: five hits.
    if2.A    = 5'b0;
    if2.IVLD = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    if2.IVLD = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("cnt_sat", 32'(if2.CNT), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
